// File: rtl/id_stage_hs.sv
// id_stage_hs -- decode stage with valid/ready handshakes and write-through register file.
//
// Decodes the RV32I subset (R, I-ALU, LW, SW, BEQ/BNE, JAL, JALR). It holds the
// architectural register file (x0 hardwired to zero, same-cycle writeback bypass).
// It also drives the ID/EX register. A load-latency scoreboard inserts bubbles
// between a load and a dependent instruction.
//
// Handshake semantics (both sides):
//   A transfer happens on a rising edge where valid and ready are both 1. A
//   producer holding valid=1 keeps its payload stable until the transfer. The
//   ID/EX register advances when EX takes it or when it is empty:
//   adv = out_ready | ~out_valid.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_ready     IF -> ID handshake; in_instr, in_pc, in_pred_taken payload
//   flush                 kills the instruction offered by IF/ID and empties ID/EX
//   wb_en/wb_addr/wb_data register file write port (always honoured)
//   out_valid/out_ready   ID/EX -> EX handshake; out_* are the registered decoded fields
//   perf_issue_cnt        issued instructions
//   perf_stall_cnt        hazard bubble cycles
//
// Parameters: XLEN (data width), NUM_REGS (16 or 32), LOAD_LAT (1..3).
// Optional feature macro: ID_PERF_CNT_EN enables the two performance counters.
// When the macro is undefined, both counter ports read 0.
module id_stage_hs #(
   parameter int XLEN     = 32,
   parameter int NUM_REGS = 32,
   parameter int LOAD_LAT = 1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     in_instr,
   input  logic [XLEN-1:0] in_pc,
   input  logic            in_pred_taken,
   input  logic            flush,
   input  logic            wb_en,
   input  logic [4:0]      wb_addr,
   input  logic [XLEN-1:0] wb_data,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [4:0]      out_rd,
   output logic [4:0]      out_rs1,
   output logic [4:0]      out_rs2,
   output logic [XLEN-1:0] out_data1,
   output logic [XLEN-1:0] out_data2,
   output logic [XLEN-1:0] out_imm,
   output logic [XLEN-1:0] out_pc,
   output logic            out_pred_taken,
   output logic            out_is_branch,
   output logic [1:0]      out_branch_type,
   output logic [1:0]      out_mem,
   output logic            out_wb,
   output logic [3:0]      out_alu_op,
   output logic            out_alu_src,
   output logic            out_illegal,
   output logic [31:0]     perf_issue_cnt,
   output logic [31:0]     perf_stall_cnt
);
   localparam int         AW   = $clog2(NUM_REGS);
   localparam logic [5:0] NREG = 6'(NUM_REGS);

   localparam logic [6:0] OP_R    = 7'b0110011;
   localparam logic [6:0] OP_I    = 7'b0010011;
   localparam logic [6:0] OP_LW   = 7'b0000011;
   localparam logic [6:0] OP_SW   = 7'b0100011;
   localparam logic [6:0] OP_BR   = 7'b1100011;
   localparam logic [6:0] OP_JAL  = 7'b1101111;
   localparam logic [6:0] OP_JALR = 7'b1100111;

   localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2, ALU_OR  = 4'd3,
                          ALU_XOR = 4'd4, ALU_SLL = 4'd5, ALU_SRL = 4'd6, ALU_SRA = 4'd7,
                          ALU_SLT = 4'd8;

   logic [XLEN-1:0] regs [NUM_REGS];
   logic [4:0]      sb   [LOAD_LAT];

   function automatic logic in_range(input logic [4:0] a);
      return {1'b0, a} < NREG;
   endfunction

   // funct7[5] only means SUB for R-type; on ADDI that bit is immediate data.
   function automatic logic [3:0] alu_from_f3(input logic [2:0] f3, input logic alt,
                                              input logic is_r);
      case (f3)
         3'b000:  return (is_r && alt) ? ALU_SUB : ALU_ADD;
         3'b001:  return ALU_SLL;
         3'b100:  return ALU_XOR;
         3'b101:  return alt ? ALU_SRA : ALU_SRL;
         3'b110:  return ALU_OR;
         3'b111:  return ALU_AND;
         default: return ALU_SLT;
      endcase
   endfunction

   // ---------------- decode ----------------
   logic [6:0]      opc;
   logic [4:0]      rd_f, rs1_f, rs2_f;
   logic            use_rd, use_rs1, use_rs2, bad_op, bad_reg, d_illegal;
   logic [4:0]      d_rd, d_rs1, d_rs2;
   logic [XLEN-1:0] d_imm, d_data1, d_data2;
   logic [3:0]      d_alu;
   logic            d_src, d_wb, d_br;
   logic [1:0]      d_bt, d_mem;

   always_comb begin
      opc     = in_instr[6:0];
      rd_f    = in_instr[11:7];
      rs1_f   = in_instr[19:15];
      rs2_f   = in_instr[24:20];
      use_rd  = 1'b0;
      use_rs1 = 1'b0;
      use_rs2 = 1'b0;
      bad_op  = 1'b0;
      d_imm   = '0;
      d_alu   = ALU_ADD;
      d_src   = 1'b1;
      d_wb    = 1'b0;
      d_mem   = 2'b00;
      d_br    = 1'b0;
      d_bt    = 2'd0;
      case (opc)
         OP_R: begin
            use_rd = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1;
            d_src  = 1'b0; d_wb = 1'b1;
            d_alu  = alu_from_f3(in_instr[14:12], in_instr[30], 1'b1);
         end
         OP_I: begin
            use_rd = 1'b1; use_rs1 = 1'b1; d_wb = 1'b1;
            d_imm  = {{(XLEN-12){in_instr[31]}}, in_instr[31:20]};
            d_alu  = alu_from_f3(in_instr[14:12], in_instr[30], 1'b0);
         end
         OP_LW: begin
            use_rd = 1'b1; use_rs1 = 1'b1; d_wb = 1'b1; d_mem = 2'b10;
            d_imm  = {{(XLEN-12){in_instr[31]}}, in_instr[31:20]};
         end
         OP_SW: begin
            use_rs1 = 1'b1; use_rs2 = 1'b1; d_mem = 2'b01;
            d_imm   = {{(XLEN-12){in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
         end
         OP_BR: begin
            use_rs1 = 1'b1; use_rs2 = 1'b1; d_src = 1'b0;
            d_alu   = ALU_SUB; d_br = 1'b1;
            d_bt    = in_instr[12] ? 2'd3 : 2'd2;
            d_imm   = {{(XLEN-13){in_instr[31]}}, in_instr[31], in_instr[7],
                       in_instr[30:25], in_instr[11:8], 1'b0};
         end
         OP_JAL: begin
            use_rd = 1'b1; d_wb = 1'b1; d_br = 1'b1; d_bt = 2'd0;
            d_imm  = {{(XLEN-21){in_instr[31]}}, in_instr[31], in_instr[19:12],
                      in_instr[20], in_instr[30:21], 1'b0};
         end
         OP_JALR: begin
            use_rd = 1'b1; use_rs1 = 1'b1; d_wb = 1'b1; d_br = 1'b1; d_bt = 2'd1;
            d_imm  = {{(XLEN-12){in_instr[31]}}, in_instr[31:20]};
         end
         default: bad_op = 1'b1;
      endcase
      d_rd      = use_rd  ? rd_f  : 5'd0;
      d_rs1     = use_rs1 ? rs1_f : 5'd0;
      d_rs2     = use_rs2 ? rs2_f : 5'd0;
      bad_reg   = (use_rd && !in_range(rd_f)) || (use_rs1 && !in_range(rs1_f)) ||
                  (use_rs2 && !in_range(rs2_f));
      d_illegal = bad_op | bad_reg;
      // Illegal instructions travel down the pipe but must have no side effects.
      if (d_illegal) begin
         d_wb  = 1'b0;
         d_mem = 2'b00;
         d_br  = 1'b0;
         d_bt  = 2'd0;
      end
   end

   // ---------------- register read with writeback bypass ----------------
   always_comb begin
      d_data1 = '0;
      d_data2 = '0;
      if (d_rs1 != 5'd0 && in_range(d_rs1))
         d_data1 = (wb_en && wb_addr == d_rs1) ? wb_data : regs[d_rs1[AW-1:0]];
      if (d_rs2 != 5'd0 && in_range(d_rs2))
         d_data2 = (wb_en && wb_addr == d_rs2) ? wb_data : regs[d_rs2[AW-1:0]];
   end

   // ---------------- hazard and handshake ----------------
   logic adv, hazard, sb_hit;

   always_comb begin
      sb_hit = 1'b0;
      for (int k = 0; k < LOAD_LAT; k++) begin
         if (sb[k] != 5'd0 && ((d_rs1 != 5'd0 && d_rs1 == sb[k]) ||
                               (d_rs2 != 5'd0 && d_rs2 == sb[k])))
            sb_hit = 1'b1;
      end
      adv      = out_ready | ~out_valid;
      hazard   = in_valid & ~flush & sb_hit;
      in_ready = flush | (adv & ~hazard);
   end

   // ---------------- register file ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      end else if (wb_en && wb_addr != 5'd0 && in_range(wb_addr)) begin
         regs[wb_addr[AW-1:0]] <= wb_data;
      end
   end

   // ---------------- ID/EX register and scoreboard ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid       <= 1'b0;
         out_rd          <= '0;
         out_rs1         <= '0;
         out_rs2         <= '0;
         out_data1       <= '0;
         out_data2       <= '0;
         out_imm         <= '0;
         out_pc          <= '0;
         out_pred_taken  <= 1'b0;
         out_is_branch   <= 1'b0;
         out_branch_type <= '0;
         out_mem         <= '0;
         out_wb          <= 1'b0;
         out_alu_op      <= '0;
         out_alu_src     <= 1'b0;
         out_illegal     <= 1'b0;
         for (int k = 0; k < LOAD_LAT; k++) sb[k] <= '0;
      end else begin
         // Older scoreboard entries age only when the pipe moves.
         if (adv) for (int k = 1; k < LOAD_LAT; k++) sb[k] <= sb[k-1];
         if (flush) begin
            out_valid <= 1'b0;
            sb[0]     <= '0;
         end else if (adv) begin
            if (in_valid && !hazard) begin
               out_valid       <= 1'b1;
               out_rd          <= d_rd;
               out_rs1         <= d_rs1;
               out_rs2         <= d_rs2;
               out_data1       <= d_data1;
               out_data2       <= d_data2;
               out_imm         <= d_imm;
               out_pc          <= in_pc;
               out_pred_taken  <= in_pred_taken;
               out_is_branch   <= d_br;
               out_branch_type <= d_bt;
               out_mem         <= d_mem;
               out_wb          <= d_wb;
               out_alu_op      <= d_alu;
               out_alu_src     <= d_src;
               out_illegal     <= d_illegal;
               sb[0]           <= d_mem[1] ? d_rd : 5'd0;
            end else begin
               out_valid <= 1'b0;
               sb[0]     <= '0;
            end
         end
      end
   end

`ifdef ID_PERF_CNT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_issue_cnt <= '0;
         perf_stall_cnt <= '0;
      end else begin
         if (!flush && adv && in_valid && !hazard) perf_issue_cnt <= perf_issue_cnt + 32'd1;
         if (adv && hazard) perf_stall_cnt <= perf_stall_cnt + 32'd1;
      end
   end
`else
   assign perf_issue_cnt = '0;
   assign perf_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_id_stage_hs.sv
// Directed bench for id_stage_hs. Three instances share clk/rst_n:
//   index 0: NUM_REGS=32, LOAD_LAT=1   index 1: NUM_REGS=16, LOAD_LAT=1
//   index 2: NUM_REGS=32, LOAD_LAT=3
module tb_id_stage_hs;
   localparam logic [31:0] I_ADD_6_5_0  = 32'h0002_8333;
   localparam logic [31:0] I_SUB_3_1_2  = 32'h4020_81B3;
   localparam logic [31:0] I_SW_2_8_1   = 32'h0020_A423;
   localparam logic [31:0] I_JAL_1_16   = 32'h0100_00EF;
   localparam logic [31:0] I_LW_7_4_1   = 32'h0040_A383;
   localparam logic [31:0] I_ADDI_8_7_1 = 32'h0013_8413;
   localparam logic [31:0] I_BEQ_1_2_M8 = 32'hFE20_8CE3;
   localparam logic [31:0] I_ADD_17_1_2 = 32'h0020_88B3;
   localparam logic [31:0] I_ADD_3_4_0  = 32'h0002_01B3;
   localparam logic [31:0] I_ADD_3_0_0  = 32'h0000_01B3;
   localparam logic [31:0] I_ADD_10_9_0 = 32'h0004_8533;
   localparam logic [31:0] I_ADD_11_20_0= 32'h000A_05B3;
`ifdef ID_PERF_CNT_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n;
   int   checks = 0;
   int   errors = 0;

   logic        in_valid [3], in_ready [3], in_pred_taken [3], flush [3];
   logic        wb_en [3], out_valid [3], out_ready [3];
   logic [31:0] in_instr [3], in_pc [3], wb_data [3];
   logic [4:0]  wb_addr [3], out_rd [3], out_rs1 [3], out_rs2 [3];
   logic [31:0] out_data1 [3], out_data2 [3], out_imm [3], out_pc [3];
   logic        out_pred_taken [3], out_is_branch [3], out_wb [3], out_alu_src [3];
   logic        out_illegal [3];
   logic [1:0]  out_branch_type [3], out_mem [3];
   logic [3:0]  out_alu_op [3];
   logic [31:0] perf_issue_cnt [3], perf_stall_cnt [3];

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   generate
      for (genvar g = 0; g < 3; g++) begin : g_dut
         id_stage_hs #(.XLEN(32), .NUM_REGS(g == 1 ? 16 : 32), .LOAD_LAT(g == 2 ? 3 : 1)) dut (
            .clk(clk), .rst_n(rst_n),
            .in_valid(in_valid[g]), .in_ready(in_ready[g]), .in_instr(in_instr[g]),
            .in_pc(in_pc[g]), .in_pred_taken(in_pred_taken[g]), .flush(flush[g]),
            .wb_en(wb_en[g]), .wb_addr(wb_addr[g]), .wb_data(wb_data[g]),
            .out_valid(out_valid[g]), .out_ready(out_ready[g]),
            .out_rd(out_rd[g]), .out_rs1(out_rs1[g]), .out_rs2(out_rs2[g]),
            .out_data1(out_data1[g]), .out_data2(out_data2[g]), .out_imm(out_imm[g]),
            .out_pc(out_pc[g]), .out_pred_taken(out_pred_taken[g]),
            .out_is_branch(out_is_branch[g]), .out_branch_type(out_branch_type[g]),
            .out_mem(out_mem[g]), .out_wb(out_wb[g]), .out_alu_op(out_alu_op[g]),
            .out_alu_src(out_alu_src[g]), .out_illegal(out_illegal[g]),
            .perf_issue_cnt(perf_issue_cnt[g]), .perf_stall_cnt(perf_stall_cnt[g])
         );
      end
   endgenerate

   // ---------------- driver tasks ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_in(input int g, input logic v, input logic [31:0] ins,
                         input logic [31:0] pc);
      in_valid[g] = v;
      in_instr[g] = ins;
      in_pc[g]    = pc;
   endtask

   task automatic set_wb(input int g, input logic en, input logic [4:0] a,
                         input logic [31:0] d);
      wb_en[g]   = en;
      wb_addr[g] = a;
      wb_data[g] = d;
   endtask

   // ---------------- scoreboard check ----------------
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
      end
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int bubbles;
      for (int g = 0; g < 3; g++) begin
         set_in(g, 1'b0, 32'h0, 32'h0);
         set_wb(g, 1'b0, 5'd0, 32'h0);
         in_pred_taken[g] = 1'b0;
         flush[g]         = 1'b0;
         out_ready[g]     = 1'b1;
      end
      rst_n = 1'b1;
      #2 rst_n = 1'b0;
      #1;
      check("rst_out_valid", 32'(out_valid[0]), 0);
      check("rst_out_imm",   out_imm[0], 0);
      check("rst_perf_issue", perf_issue_cnt[0], 0);
      @(posedge clk);
      @(posedge clk);
      #2 rst_n = 1'b1;
      step();

      // write x5 and read it in the same cycle through the bypass
      set_wb(0, 1'b1, 5'd5, 32'h1234);
      set_in(0, 1'b1, I_ADD_6_5_0, 32'h100);
      #1 check("add_in_ready", 32'(in_ready[0]), 1);
      step();
      set_wb(0, 1'b0, 5'd0, 32'h0);
      check("add_valid",   32'(out_valid[0]), 1);
      check("add_data1",   out_data1[0], 32'h1234);
      check("add_alu_op",  32'(out_alu_op[0]), 0);
      check("add_alu_src", 32'(out_alu_src[0]), 0);
      check("add_wb",      32'(out_wb[0]), 1);
      check("add_rd",      32'(out_rd[0]), 6);
      check("add_pc",      out_pc[0], 32'h100);

      set_in(0, 1'b1, I_SUB_3_1_2, 32'h104);
      step();
      check("sub_alu_op", 32'(out_alu_op[0]), 1);
      check("sub_rs2",    32'(out_rs2[0]), 2);

      set_in(0, 1'b1, I_SW_2_8_1, 32'h108);
      step();
      check("sw_mem",     32'(out_mem[0]), 1);
      check("sw_wb",      32'(out_wb[0]), 0);
      check("sw_imm",     out_imm[0], 8);
      check("sw_alu_src", 32'(out_alu_src[0]), 1);

      set_in(0, 1'b1, I_JAL_1_16, 32'h10C);
      step();
      check("jal_is_branch", 32'(out_is_branch[0]), 1);
      check("jal_btype",     32'(out_branch_type[0]), 0);
      check("jal_imm",       out_imm[0], 16);
      check("jal_rs1",       32'(out_rs1[0]), 0);
      check("jal_wb",        32'(out_wb[0]), 1);

      // load-use with LOAD_LAT=1: exactly one bubble
      set_in(0, 1'b1, I_LW_7_4_1, 32'h110);
      step();
      check("lw_mem", 32'(out_mem[0]), 2);
      check("lw_imm", out_imm[0], 4);
      set_in(0, 1'b1, I_ADDI_8_7_1, 32'h114);
      #1 check("lu_in_ready_low", 32'(in_ready[0]), 0);
      step();
      check("lu_bubble", 32'(out_valid[0]), 0);
      check("lu_in_ready_high", 32'(in_ready[0]), 1);
      step();
      check("addi_valid", 32'(out_valid[0]), 1);
      check("addi_rd",    32'(out_rd[0]), 8);
      check("addi_imm",   out_imm[0], 1);
      check("addi_rs2",   32'(out_rs2[0]), 0);
      set_in(0, 1'b0, 32'h0, 32'h0);
      step();
      check("idle_valid", 32'(out_valid[0]), 0);

      // x20 is a real register with 32 entries
      set_wb(0, 1'b1, 5'd20, 32'h2020);
      step();
      set_wb(0, 1'b0, 5'd0, 32'h0);
      set_in(0, 1'b1, I_ADD_11_20_0, 32'h118);
      step();
      check("x20_read32", out_data1[0], 32'h2020);

      // flush over a valid load in ID/EX, with a writeback in the same cycle
      set_in(0, 1'b1, I_LW_7_4_1, 32'h11C);
      step();
      set_in(0, 1'b1, I_JAL_1_16, 32'h120);
      flush[0] = 1'b1;
      set_wb(0, 1'b1, 5'd9, 32'hABCD);
      #1 check("flush_in_ready", 32'(in_ready[0]), 1);
      step();
      flush[0] = 1'b0;
      set_wb(0, 1'b0, 5'd0, 32'h0);
      check("flush_valid", 32'(out_valid[0]), 0);
      set_in(0, 1'b1, I_ADDI_8_7_1, 32'h124);
      #1 check("flush_sb_clear", 32'(in_ready[0]), 1);
      step();
      check("post_flush_issue", 32'(out_valid[0]), 1);
      check("post_flush_rd",    32'(out_rd[0]), 8);
      set_in(0, 1'b1, I_ADD_10_9_0, 32'h128);
      step();
      check("flush_wb_taken", out_data1[0], 32'hABCD);

      // backpressure: beq held for 4 cycles
      set_in(0, 1'b1, I_BEQ_1_2_M8, 32'h200);
      step();
      out_ready[0] = 1'b0;
      set_in(0, 1'b1, I_ADD_6_5_0, 32'h204);
      for (int i = 0; i < 4; i++) begin
         #1;
         check("hold_in_ready", 32'(in_ready[0]), 0);
         check("hold_valid",    32'(out_valid[0]), 1);
         check("hold_imm",      out_imm[0], 32'hFFFF_FFF8);
         check("hold_btype",    32'(out_branch_type[0]), 2);
         check("hold_pc",       out_pc[0], 32'h200);
         step();
      end
      out_ready[0] = 1'b1;
      step();
      check("release_pc", out_pc[0], 32'h204);
      set_in(0, 1'b0, 32'h0, 32'h0);

      // NUM_REGS=16 instance
      set_in(1, 1'b1, I_ADD_17_1_2, 32'h300);
      step();
      check("rv32e_illegal", 32'(out_illegal[1]), 1);
      check("rv32e_wb",      32'(out_wb[1]), 0);
      check("rv32e_valid",   32'(out_valid[1]), 1);
      set_in(1, 1'b1, 32'hFFFF_FFFF, 32'h304);
      step();
      check("badop_illegal", 32'(out_illegal[1]), 1);
      check("badop_mem",     32'(out_mem[1]), 0);
      check("badop_branch",  32'(out_is_branch[1]), 0);
      set_in(1, 1'b0, 32'h0, 32'h0);
      set_wb(1, 1'b1, 5'd20, 32'h5555);
      step();
      set_wb(1, 1'b1, 5'd0, 32'hFFFF);
      set_in(1, 1'b1, I_ADD_3_0_0, 32'h308);
      step();
      check("x0_bypass", out_data1[1], 0);
      set_wb(1, 1'b0, 5'd0, 32'h0);
      set_in(1, 1'b1, I_ADD_3_4_0, 32'h30C);
      step();
      check("x20_not_x4",   out_data1[1], 0);
      check("legal_rv32e",  32'(out_illegal[1]), 0);
      set_in(1, 1'b1, I_ADD_3_0_0, 32'h310);
      step();
      check("x0_readback", out_data1[1], 0);
      set_in(1, 1'b0, 32'h0, 32'h0);

      // LOAD_LAT=3: three bubbles between lw and dependent addi
      set_in(2, 1'b1, I_LW_7_4_1, 32'h400);
      step();
      set_in(2, 1'b1, I_ADDI_8_7_1, 32'h404);
      bubbles = 0;
      for (int i = 0; i < 10; i++) begin
         step();
         if (out_valid[2]) break;
         bubbles++;
      end
      set_in(2, 1'b0, 32'h0, 32'h0);
      check("ll3_issued",   32'(out_valid[2]), 1);
      check("ll3_rd",       32'(out_rd[2]), 8);
      check("ll3_bubbles",  32'(bubbles), 3);
      check("ll3_perf_stall", perf_stall_cnt[2], PERF ? 32'd3 : 32'd0);
      check("ll3_perf_issue", perf_issue_cnt[2], PERF ? 32'd2 : 32'd0);

      // asynchronous reset mid-stall
      set_in(0, 1'b1, I_BEQ_1_2_M8, 32'h500);
      step();
      out_ready[0] = 1'b0;
      set_in(0, 1'b1, I_ADD_6_5_0, 32'h504);
      #3 rst_n = 1'b0;
      #1;
      check("arst_valid", 32'(out_valid[0]), 0);
      check("arst_imm",   out_imm[0], 0);
      check("arst_pc",    out_pc[0], 0);
      check("arst_btype", 32'(out_branch_type[0]), 0);
      #2 rst_n = 1'b1;
      set_in(0, 1'b0, 32'h0, 32'h0);
      out_ready[0] = 1'b1;
      step();
      check("arst_in_ready", 32'(in_ready[0]), 1);
      check("arst_idle",     32'(out_valid[0]), 0);
      set_in(0, 1'b1, I_ADD_6_5_0, 32'h508);
      step();
      check("arst_rf_clear", out_data1[0], 0);
      set_in(0, 1'b0, 32'h0, 32'h0);
      step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
